// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: BHT saturating counters plus BTB targets.
// Lookup (IF) and mispredict detection (ID) are combinational reads of the
// registered table; one write port commits the ID-stage update on clk_i.
// Optional build macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic            upd_mispredict_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
`endif
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));

  logic                valid_q [ENTRIES];
  logic [TAGW-1:0]     tag_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];

  logic [IDX-1:0]      lk_idx, up_idx;
  logic [TAGW-1:0]     lk_tag, up_tag;
  logic                lk_hit, up_hit, up_ptaken;
  logic [XLEN-1:0]     up_ptarget;

  logic                wr_en;
  logic [TAGW-1:0]     wr_tag_d;
  logic [CTR_BITS-1:0] wr_ctr_d;
  logic [XLEN-1:0]     wr_tgt_d;

  assign lk_idx = pc_i[IDX+1:2];
  assign lk_tag = pc_i[XLEN-1:IDX+2];
  assign up_idx = upd_pc_i[IDX+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDX+2];

  // IF-side lookup for the fetch PC
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    hit_o         = lk_hit;
    pred_taken_o  = start_i && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + XLEN'(4);
  end

  // ID-side re-lookup of the resolving branch and mispredict detection
  always_comb begin
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ptaken  = start_i && up_hit && ctr_q[up_idx][CTR_BITS-1];
    up_ptarget = up_ptaken ? tgt_q[up_idx] : upd_pc_i + XLEN'(4);
    upd_mispredict_o = upd_valid_i &&
                       ((up_ptaken != upd_taken_i) ||
                        (upd_taken_i && up_ptaken && (up_ptarget != upd_target_i)));
  end

  // Next contents of the written entry: train on hit, allocate on taken miss
  always_comb begin
    wr_en    = upd_valid_i && start_i && (up_hit || upd_taken_i);
    wr_tag_d = up_tag;
    wr_ctr_d = ctr_q[up_idx];
    wr_tgt_d = tgt_q[up_idx];
    if (up_hit) begin
      if (upd_taken_i) begin
        if (ctr_q[up_idx] != '1) wr_ctr_d = ctr_q[up_idx] + CTR_BITS'(1);
        wr_tgt_d = upd_target_i;
      end else if (ctr_q[up_idx] != '0) begin
        wr_ctr_d = ctr_q[up_idx] - CTR_BITS'(1);
      end
    end else begin
      wr_ctr_d = CTR_WT;
      wr_tgt_d = upd_target_i;
    end
  end

  // Table storage: async clear, single write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
        tgt_q[i]   <= '0;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= wr_tag_d;
      ctr_q[up_idx]   <= wr_ctr_d;
      tgt_q[up_idx]   <= wr_tgt_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating statistics for qualifying updates
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid_i && start_i) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
      if (upd_mispredict_o && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, CTR_BITS=2) against
// an array-based reference model; define BP_STATS_EN to cover the counters.
module tb_branch_predictor;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CB      = 2;
  localparam int CMAX = (1 << CB) - 1;
  localparam int WNT  = (1 << (CB - 1)) - 1;
  localparam int WT   = 1 << (CB - 1);

  logic clk = 1'b0;
  logic rst, start, uv, ut;
  logic [31:0] pc, upc, utg;
  logic hit, ptk, mp;
  logic [31:0] ptg;
`ifdef BP_STATS_EN
  logic [31:0] st_br, st_mp;
  logic [31:0] m_st_br, m_st_mp;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CB)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
    .hit_o(hit), .pred_taken_o(ptk), .pred_target_o(ptg),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .upd_target_i(utg),
    .upd_mispredict_o(mp)
`ifdef BP_STATS_EN
    , .stat_branches_o(st_br), .stat_mispred_o(st_mp)
`endif
  );

  // Reference model: one record per table slot
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  int n_cmp  = 0;
  int n_fail = 0;
  logic e_hit, e_tk, e_mp;
  logic [31:0] e_tg;

  function automatic void m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = WNT;
    end
`ifdef BP_STATS_EN
    m_st_br = '0; m_st_mp = '0;
`endif
  endfunction

  function automatic void m_look(input logic [31:0] a, input logic s,
                                 output logic h, output logic t, output logic [31:0] g);
    int unsigned ix = (a / 4) % ENTRIES;
    logic [31:0] tg = a / (4 * ENTRIES);
    h = m_valid[ix] && (m_tag[ix] == tg);
    t = s && h && (m_ctr[ix] >= WT);
    g = t ? m_tgt[ix] : a + 32'd4;
  endfunction

  function automatic void m_upd(input logic [31:0] a, input logic tk, input logic [31:0] target);
    int unsigned ix = (a / 4) % ENTRIES;
    logic [31:0] tg = a / (4 * ENTRIES);
    if (m_valid[ix] && (m_tag[ix] == tg)) begin
      if (tk) begin
        m_ctr[ix] = (m_ctr[ix] < CMAX) ? m_ctr[ix] + 1 : CMAX;
        m_tgt[ix] = target;
      end else begin
        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[ix] = 1'b1; m_tag[ix] = tg; m_tgt[ix] = target; m_ctr[ix] = WT;
    end
  endfunction

  // Drive one cycle's inputs after the falling edge and form expectations
  task automatic apply(input logic [31:0] a_pc, input logic a_uv, input logic [31:0] a_upc,
                       input logic a_ut, input logic [31:0] a_utg, input logic a_st);
    logic ph, pt;
    logic [31:0] pg;
    @(negedge clk);
    pc = a_pc; uv = a_uv; upc = a_upc; ut = a_ut; utg = a_utg; start = a_st;
    #1;
    m_look(a_pc, a_st, e_hit, e_tk, e_tg);
    m_look(a_upc, a_st, ph, pt, pg);
    e_mp = a_uv && ((pt != a_ut) || (a_ut && pt && (pg != a_utg)));
  endtask

  // Let the rising edge commit and mirror it in the model
  task automatic commit();
    @(posedge clk);
    if (!rst && uv && start) begin
`ifdef BP_STATS_EN
      if (m_st_br != 32'hFFFF_FFFF) m_st_br = m_st_br + 1;
      if (e_mp && (m_st_mp != 32'hFFFF_FFFF)) m_st_mp = m_st_mp + 1;
`endif
      m_upd(upc, ut, utg);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; uv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    apply(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit); end
    n_cmp++; if (ptk !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", ptk); end
    n_cmp++; if (ptg !== 32'h14) begin n_fail++; $display("FAIL reset_target: got %h want 00000014", ptg); end
`ifdef BP_STATS_EN
    n_cmp++; if (st_br !== 32'h0 || st_mp !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", st_br, st_mp); end
`endif
    commit();
    apply(32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (ptg !== 32'h2) begin n_fail++; $display("FAIL wrap_target: got %h want 00000002", ptg); end
    commit();
  endtask

  task automatic test_train();
    apply(32'h20, 1'b1, 32'h20, 1'b1, 32'h40, 1'b1);
    n_cmp++; if (mp !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict: got %b want 1", mp); end
    commit();
    apply(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({hit, ptk} !== 2'b11 || ptg !== 32'h40) begin
      n_fail++; $display("FAIL alloc_lookup: got hit=%b tk=%b tg=%h want 1 1 00000040", hit, ptk, ptg); end
    commit();
    repeat (2) begin
      apply(32'h20, 1'b1, 32'h20, 1'b1, 32'h40, 1'b1);
      n_cmp++; if (mp !== 1'b0) begin n_fail++; $display("FAIL train_mispredict: got %b want 0", mp); end
      commit();
    end
    apply(32'h20, 1'b1, 32'h20, 1'b0, 32'h40, 1'b1);
    n_cmp++; if (ptk !== 1'b1 || mp !== 1'b1) begin
      n_fail++; $display("FAIL nt1: got tk=%b mp=%b want 1 1", ptk, mp); end
    commit();
    apply(32'h20, 1'b1, 32'h20, 1'b0, 32'h40, 1'b1);
    n_cmp++; if (ptk !== 1'b1 || mp !== e_mp) begin
      n_fail++; $display("FAIL nt2: got tk=%b mp=%b want 1 %b", ptk, mp, e_mp); end
    commit();
    apply(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({hit, ptk} !== 2'b10 || ptg !== 32'h24) begin
      n_fail++; $display("FAIL nt_after: got hit=%b tk=%b tg=%h want 1 0 00000024", hit, ptk, ptg); end
    commit();
  endtask

  task automatic test_alias();
    apply(32'h20, 1'b1, 32'h60, 1'b1, 32'h80, 1'b1);
    n_cmp++; if (hit !== 1'b1 || mp !== 1'b1) begin
      n_fail++; $display("FAIL alias_pre: got hit=%b mp=%b want 1 1", hit, mp); end
    commit();
    apply(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL alias_evicted: got %b want 0", hit); end
    commit();
    apply(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({hit, ptk} !== 2'b11 || ptg !== 32'h80) begin
      n_fail++; $display("FAIL alias_new: got hit=%b tk=%b tg=%h want 1 1 00000080", hit, ptk, ptg); end
    commit();
    apply(32'h60, 1'b1, 32'h60, 1'b1, 32'h80, 1'b0);
    n_cmp++; if (ptk !== 1'b0 || hit !== 1'b1 || mp !== 1'b1) begin
      n_fail++; $display("FAIL stopped: got hit=%b tk=%b mp=%b want 1 0 1", hit, ptk, mp); end
    commit();
  endtask

  task automatic test_same_cycle_reset();
    apply(32'h60, 1'b1, 32'h60, 1'b1, 32'h123, 1'b1);
    n_cmp++; if (ptg !== 32'h80 || mp !== 1'b1) begin
      n_fail++; $display("FAIL nobypass: got tg=%h mp=%b want 00000080 1", ptg, mp); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({hit, ptk} !== 2'b00 || ptg !== 32'h64) begin
      n_fail++; $display("FAIL async_rst: got hit=%b tk=%b tg=%h want 0 0 00000064", hit, ptk, ptg); end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; uv = 1'b0;
    #1;
    n_cmp++; if (hit !== 1'b0) begin n_fail++; $display("FAIL rst_discard: got %b want 0", hit); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
      b = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFFC | $urandom_range(0, 3);
      apply(a, ($urandom_range(0, 3) != 0), b, ($urandom_range(0, 9) < 6),
            $urandom_range(0, 3) << 8, ($urandom_range(0, 7) != 0));
      n_cmp++; if (hit !== e_hit) begin n_fail++; $display("FAIL rnd_hit[%0d]: got %b want %b", n, hit, e_hit); end
      n_cmp++; if (ptk !== e_tk) begin n_fail++; $display("FAIL rnd_taken[%0d]: got %b want %b", n, ptk, e_tk); end
      n_cmp++; if (ptg !== e_tg) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", n, ptg, e_tg); end
      n_cmp++; if (mp !== e_mp) begin n_fail++; $display("FAIL rnd_mispredict[%0d]: got %b want %b", n, mp, e_mp); end
`ifdef BP_STATS_EN
      n_cmp++; if (st_br !== m_st_br || st_mp !== m_st_mp) begin
        n_fail++; $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", n, st_br, st_mp, m_st_br, m_st_mp); end
`endif
      commit();
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    do_reset();
    apply(32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1); commit();
    apply(32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1); commit();
    apply(32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1); commit();
    apply(32'h0, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1); commit();
    apply(32'h0, 1'b1, 32'h104, 1'b0, 32'h200, 1'b1); commit();
    apply(32'h0, 1'b1, 32'h100, 1'b0, 32'h200, 1'b0); commit();
    apply(32'h0, 1'b1, 32'h108, 1'b1, 32'h200, 1'b0); commit();
    apply(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (st_br !== 32'd5) begin n_fail++; $display("FAIL stat_branches: got %0d want 5", st_br); end
    n_cmp++; if (st_mp !== 32'd2) begin n_fail++; $display("FAIL stat_mispred: got %0d want 2", st_mp); end
    commit();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b1; uv = 1'b0; ut = 1'b0;
    pc = '0; upc = '0; utg = '0;
    m_reset();
    test_reset();
    test_train();
    test_alias();
    test_same_cycle_reset();
    test_back_to_back();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
